// File: rtl/sub_share_pkg.sv
// Shared constants and helpers for PE resources that are time-shared
// between several requesters under round-robin arbitration.
package sub_share_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int CNT_W_DEF   = 32;

    // Round-robin successor of ptr in the range 0..n-1.
    function automatic logic [31:0] rr_next(input logic [31:0] ptr, input logic [31:0] n);
        logic [31:0] nxt;
        nxt = ptr + 32'd1;
        if (nxt >= n) begin
            nxt = 32'd0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sub_share_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared subtractor.
// Requester i occupies bit i of each vector and bits [i*DATA_W +: DATA_W] of each bus.
interface sub_share_arbiter_if
    import sub_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [NUM_REQ*DATA_W-1:0] rsp_diff;
    logic [NUM_REQ-1:0]        rsp_borrow;

    // Requester side.
    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_diff,
        input  rsp_borrow
    );

    // Shared-resource side.
    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_diff,
        output rsp_borrow
    );

endinterface

// File: rtl/Subtraction.sv
// 32-bit unsigned subtractor: Diff = A - B modulo 2^32, Borrow = (A < B).
module Subtraction (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Diff,
    output logic        Borrow
);

    logic [32:0] full;

    // The extra top bit of a zero-extended subtraction is exactly the borrow.
    assign full   = {1'b0, A} - {1'b0, B};
    assign Diff   = full[31:0];
    assign Borrow = full[32];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req from ptr upward (wrapping)
// and returns a one-hot grant, its index and whether anything was granted.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_grant_o
);

    int idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        idx         = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_grant_o && req_i[IDX_W'(idx)]) begin
                grant_o[IDX_W'(idx)] = 1'b1;
                grant_idx_o          = IDX_W'(idx);
                any_grant_o          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sub_share_arbiter.sv
// Time-shares one Subtraction instance among NUM_REQ requesters, with a
// one-entry response slot per requester and a running count of accepted ops.
module sub_share_arbiter
    import sub_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sub_share_arbiter_if.slave   bus,
    output logic [CNT_W-1:0]     op_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0][DATA_W-1:0] rsp_diff_q,  rsp_diff_d;
    logic [NUM_REQ-1:0]             rsp_borrow_q, rsp_borrow_d;
    logic [IDX_W-1:0]               ptr_q, ptr_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               any_grant;

    logic [DATA_W-1:0]  op_a, op_b;
    logic [DATA_W-1:0]  sub_diff;
    logic               sub_borrow;

    // A full slot may accept a new result only in the cycle it is being drained.
    assign elig = bus.req_valid & (~rsp_valid_q | bus.rsp_ready);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i       (elig),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    assign bus.req_ready = rst_n ? grant : '0;

    // grant_idx is 0 when nothing is granted, so the idle mux selects requester 0.
    always_comb begin
        op_a = bus.req_a[0 +: DATA_W];
        op_b = bus.req_b[0 +: DATA_W];
        for (int i = 1; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                op_a = bus.req_a[i*DATA_W +: DATA_W];
                op_b = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    Subtraction u_sub (
        .A      (op_a),
        .B      (op_b),
        .Diff   (sub_diff),
        .Borrow (sub_borrow)
    );

    always_comb begin
        rsp_valid_d  = rsp_valid_q & ~bus.rsp_ready;
        rsp_diff_d   = rsp_diff_q;
        rsp_borrow_d = rsp_borrow_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        if (any_grant) begin
            rsp_valid_d[grant_idx]  = 1'b1;
            rsp_diff_d[grant_idx]   = sub_diff;
            rsp_borrow_d[grant_idx] = sub_borrow;
            ptr_d                   = IDX_W'(rr_next(32'(grant_idx), 32'(NUM_REQ)));
            cnt_d                   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= '0;
            rsp_diff_q   <= '0;
            rsp_borrow_q <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_diff_q   <= rsp_diff_d;
            rsp_borrow_q <= rsp_borrow_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_diff   = rsp_diff_q;
    assign bus.rsp_borrow = rsp_borrow_q;
    assign op_count       = cnt_q;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Bench for sub_share_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of the slots.
module tb_sub_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] op_count;

    sub_share_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    sub_share_arbiter #(.NUM_REQ(N), .DATA_W(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit            m_vld [N];
    logic [W-1:0]  m_diff[N];
    bit            m_bor [N];
    int            m_ptr;
    logic [CW-1:0] m_cnt;

    logic [N-1:0]  last_ready;
    int            last_g;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_vld[i]  = 1'b0;
            m_diff[i] = '0;
            m_bor[i]  = 1'b0;
        end
        m_ptr = 0;
        m_cnt = '0;
    endtask

    // First eligible requester scanning from the pointer, or -1.
    function automatic int pick();
        for (int off = 0; off < N; off++) begin
            int k;
            k = (m_ptr + off) % N;
            if (bus.req_valid[k] && (!m_vld[k] || bus.rsp_ready[k])) return k;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_valid[i]     = v;
        bus.req_a[i*W +: W]  = a;
        bus.req_b[i*W +: W]  = b;
    endtask

    task automatic cycle();
        int           g;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_vld;
        logic [W-1:0] a, b;
        @(negedge clk);
        g = pick();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        for (int i = 0; i < N; i++) exp_vld[i] = m_vld[i];
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_vld));
        chk("op_count", 64'(op_count), 64'(m_cnt));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rsp_diff%0d", i), 64'(bus.rsp_diff[i*W +: W]), 64'(m_diff[i]));
            chk($sformatf("rsp_borrow%0d", i), 64'(bus.rsp_borrow[i]), 64'(m_bor[i]));
        end
        last_ready = bus.req_ready;
        last_g     = g;
        for (int i = 0; i < N; i++) begin
            if (m_vld[i] && bus.rsp_ready[i]) m_vld[i] = 1'b0;
        end
        if (g >= 0) begin
            a = bus.req_a[g*W +: W];
            b = bus.req_b[g*W +: W];
            m_vld[g]  = 1'b1;
            m_diff[g] = a - b;
            m_bor[g]  = (a < b);
            m_ptr     = (g + 1) % N;
            m_cnt     = m_cnt + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        model_reset();
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '1;

        // Reset state with all requesters asking.
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rst_op_count", 64'(op_count), 64'h0);
        chk("rst_rsp_borrow", 64'(bus.rsp_borrow), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req_valid = '0;

        // Single op on requester 0.
        set_req(0, 1'b1, 32'd15, 32'd5);
        cycle();
        chk("single_grant", 64'(last_ready), 64'b0001);
        set_req(0, 1'b0, 32'd0, 32'd0);
        chk("single_valid", 64'(bus.rsp_valid[0]), 64'h1);
        chk("single_diff", 64'(bus.rsp_diff[0 +: W]), 64'd10);
        chk("single_borrow", 64'(bus.rsp_borrow[0]), 64'h0);
        chk("single_count", 64'(op_count), 64'd1);

        // Borrow with wrap, then equal operands.
        set_req(2, 1'b1, 32'd1, 32'hFFFF_FFFF);
        cycle();
        chk("wrap_grant", 64'(last_ready), 64'b0100);
        chk("wrap_diff", 64'(bus.rsp_diff[2*W +: W]), 64'h0000_0002);
        chk("wrap_borrow", 64'(bus.rsp_borrow[2]), 64'h1);
        set_req(2, 1'b1, 32'd25, 32'd25);
        cycle();
        chk("eq_diff", 64'(bus.rsp_diff[2*W +: W]), 64'h0);
        chk("eq_borrow", 64'(bus.rsp_borrow[2]), 64'h0);
        chk("eq_valid", 64'(bus.rsp_valid[2]), 64'h1);
        set_req(2, 1'b0, 32'd0, 32'd0);

        // Backpressure on slot 1.
        bus.rsp_ready = 4'b1101;
        set_req(1, 1'b1, 32'd20, 32'd0);
        cycle();
        chk("bp_fill_grant", 64'(last_ready), 64'b0010);
        chk("bp_fill_diff", 64'(bus.rsp_diff[1*W +: W]), 64'd20);
        set_req(0, 1'b1, 32'd3, 32'd1);
        set_req(2, 1'b1, 32'd100, 32'd7);
        set_req(3, 1'b1, 32'd0, 32'd1);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("bp_no_grant1", 64'(last_ready[1]), 64'h0);
            chk("bp_others_served", 64'(|last_ready), 64'h1);
            chk("bp_hold_diff", 64'(bus.rsp_diff[1*W +: W]), 64'd20);
            chk("bp_hold_valid", 64'(bus.rsp_valid[1]), 64'h1);
        end
        set_req(0, 1'b0, 32'd0, 32'd0);
        set_req(2, 1'b0, 32'd0, 32'd0);
        set_req(3, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b1, 32'd7, 32'd3);
        bus.rsp_ready = 4'b1111;
        cycle();
        chk("drain_capture_grant", 64'(last_ready), 64'b0010);
        chk("drain_capture_valid", 64'(bus.rsp_valid[1]), 64'h1);
        chk("drain_capture_diff", 64'(bus.rsp_diff[1*W +: W]), 64'd4);
        set_req(1, 1'b0, 32'd0, 32'd0);

        // Build rsp_valid = 1010, then reset asynchronously.
        cycle();
        bus.rsp_ready = 4'b0000;
        set_req(1, 1'b1, 32'd9, 32'd2);
        set_req(3, 1'b1, 32'd2, 32'd9);
        cycle();
        cycle();
        set_req(1, 1'b0, 32'd0, 32'd0);
        set_req(3, 1'b0, 32'd0, 32'd0);
        chk("pre_reset_valid", 64'(bus.rsp_valid), 64'b1010);
        #2;
        rst_n = 1'b0;
        bus.req_valid = '1;
        #1;
        chk("async_rst_valid", 64'(bus.rsp_valid), 64'h0);
        chk("async_rst_count", 64'(op_count), 64'h0);
        chk("async_rst_ready", 64'(bus.req_ready), 64'h0);
        chk("async_rst_diff1", 64'(bus.rsp_diff[1*W +: W]), 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full contention from pointer 0.
        bus.rsp_ready = '1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i * 11 + 40), 32'(i * 3));
        for (int k = 0; k < 6; k++) begin
            logic [N-1:0] want;
            cycle();
            want = '0;
            want[k % N] = 1'b1;
            chk("contend_grant", 64'(last_ready), 64'(want));
            chk("contend_count", 64'(op_count), 64'(k + 1));
        end

        // Randomized traffic; operands held while valid and not accepted.
        last_ready = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(bus.req_valid[i] && !last_ready[i])) begin
                    logic [W-1:0] a, b;
                    int r;
                    a = $urandom;
                    b = $urandom;
                    r = $urandom_range(0, 7);
                    if (r == 0) b = a;
                    if (r == 1) a = '0;
                    if (r == 2) b = '1;
                    if (r == 3) a = b + 32'd1;
                    set_req(i, ($urandom_range(0, 3) != 0), a, b);
                end
            end
            for (int i = 0; i < N; i++) bus.rsp_ready[i] = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
